// File: rtl/interrupt_sequencer_pkg.sv
// Shared interrupt constants: sequencer state encodings, SREG/TIFR bit
// positions and timer-0 vector addresses used by controller and sequencer.
package interrupt_sequencer_pkg;

    typedef enum logic [2:0] {
        INT_SEQ_IDLE    = 3'd0,
        INT_SEQ_PUSH_LO = 3'd1,
        INT_SEQ_PUSH_HI = 3'd2,
        INT_SEQ_JUMP    = 3'd3,
        INT_SEQ_GUARD   = 3'd4
    } int_seq_state_t;

    localparam int FLAGS_I = 7;

    localparam int TOV0  = 0;
    localparam int OCF0A = 1;
    localparam int OCF0B = 2;

    localparam logic [15:0] TIM0_COMPA_ISR = 16'h000E;
    localparam logic [15:0] TIM0_COMPB_ISR = 16'h000F;
    localparam logic [15:0] TIM0_OVF_ISR   = 16'h0010;

endpackage

// File: rtl/interrupt_sequencer.sv
// Interrupt entry sequencer: on an instruction boundary accepts irq, pushes
// the return PC (low byte first), clears I, acks the TIFR flag, jumps.
module interrupt_sequencer
    import interrupt_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int I_ADDR_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    irq,
    input  logic [I_ADDR_WIDTH-1:0] vector,
    input  logic                    instr_boundary,
    input  logic [I_ADDR_WIDTH-1:0] pc,
    input  logic [DATA_WIDTH-1:0]   sp,
    input  logic                    mem_ready,
    output logic                    stall,
    output logic                    mem_wr_en,
    output logic [DATA_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wr_data,
    output logic                    sp_wr_en,
    output logic [DATA_WIDTH-1:0]   sp_wr_data,
    output logic                    sreg_i_clr,
    output logic [DATA_WIDTH-1:0]   tifr_clr,
    output logic                    pc_load,
    output logic [I_ADDR_WIDTH-1:0] pc_next
);

    int_seq_state_t          state;
    logic [I_ADDR_WIDTH-1:0] vec_q;
    logic [I_ADDR_WIDTH-1:0] ret_q;
    logic [DATA_WIDTH-1:0]   sp_q;

    // Unmapped vectors still jump; they just acknowledge nothing.
    function automatic logic [DATA_WIDTH-1:0] tifr_mask(
        input logic [I_ADDR_WIDTH-1:0] v
    );
        logic [DATA_WIDTH-1:0] m;
        m = '0;
        unique case (1'b1)
            (16'(v) == TIM0_OVF_ISR):   m = DATA_WIDTH'(1) << TOV0;
            (16'(v) == TIM0_COMPA_ISR): m = DATA_WIDTH'(1) << OCF0A;
            (16'(v) == TIM0_COMPB_ISR): m = DATA_WIDTH'(1) << OCF0B;
            default:                    m = '0;
        endcase
        return m;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= INT_SEQ_IDLE;
            vec_q <= '0;
            ret_q <= '0;
            sp_q  <= '0;
        end else begin
            unique case (state)
                INT_SEQ_IDLE: begin
                    if (irq && instr_boundary) begin
                        vec_q <= vector;
                        ret_q <= pc;
                        sp_q  <= sp;
                        state <= INT_SEQ_PUSH_LO;
                    end
                end
                INT_SEQ_PUSH_LO: begin
                    if (mem_ready) begin
                        sp_q  <= sp_q - DATA_WIDTH'(1);
                        state <= INT_SEQ_PUSH_HI;
                    end
                end
                INT_SEQ_PUSH_HI: begin
                    if (mem_ready) begin
                        state <= INT_SEQ_JUMP;
                    end
                end
                INT_SEQ_JUMP:  state <= INT_SEQ_GUARD;
                INT_SEQ_GUARD: state <= INT_SEQ_IDLE;
                default:       state <= INT_SEQ_IDLE;
            endcase
        end
    end

    always_comb begin
        stall       = (state != INT_SEQ_IDLE);
        mem_wr_en   = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        sp_wr_en    = 1'b0;
        sp_wr_data  = '0;
        sreg_i_clr  = 1'b0;
        tifr_clr    = '0;
        pc_load     = 1'b0;
        pc_next     = '0;
        unique case (state)
            INT_SEQ_PUSH_LO: begin
                mem_wr_en   = 1'b1;
                mem_addr    = sp_q;
                mem_wr_data = DATA_WIDTH'(ret_q[7:0]);
                sreg_i_clr  = mem_ready;
            end
            INT_SEQ_PUSH_HI: begin
                mem_wr_en   = 1'b1;
                mem_addr    = sp_q;
                mem_wr_data = DATA_WIDTH'(ret_q >> 8);
                sp_wr_en    = mem_ready;
                if (mem_ready) begin
                    sp_wr_data = sp_q - DATA_WIDTH'(1);
                end
            end
            INT_SEQ_JUMP: begin
                pc_load  = 1'b1;
                pc_next  = vec_q;
                tifr_clr = tifr_mask(vec_q);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Self-checking bench: directed vector table, hand sequences and random
// traffic checked against a transaction-level model of interrupt entry.
module tb_interrupt_sequencer;
    import interrupt_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       irq;
    logic [9:0] vector;
    logic       instr_boundary;
    logic [9:0] pc;
    logic [7:0] sp;
    logic       mem_ready;
    logic       stall, mem_wr_en, sp_wr_en, sreg_i_clr, pc_load;
    logic [7:0] mem_addr, mem_wr_data, sp_wr_data, tifr_clr;
    logic [9:0] pc_next;

    localparam logic [9:0] V_OVF = 10'(TIM0_OVF_ISR);
    localparam logic [9:0] V_CA  = 10'(TIM0_COMPA_ISR);
    localparam logic [9:0] V_CB  = 10'(TIM0_COMPB_ISR);

    interrupt_sequencer #(.DATA_WIDTH(8), .I_ADDR_WIDTH(10)) dut (
        .clk(clk), .reset(reset), .irq(irq), .vector(vector),
        .instr_boundary(instr_boundary), .pc(pc), .sp(sp),
        .mem_ready(mem_ready), .stall(stall), .mem_wr_en(mem_wr_en),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .sp_wr_en(sp_wr_en), .sp_wr_data(sp_wr_data),
        .sreg_i_clr(sreg_i_clr), .tifr_clr(tifr_clr),
        .pc_load(pc_load), .pc_next(pc_next)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model: an entry is a list of pending stack writes, then a
    // jump, then one dead cycle.
    bit         m_busy, m_jump, m_guard;
    logic [7:0] q_addr[$];
    logic [7:0] q_data[$];
    logic [9:0] m_vec;
    logic [7:0] m_final;
    int         cyc, acc_cyc, pcl_cyc;
    int         n_sreg, n_spwe, n_pcl;

    function automatic logic [7:0] ref_mask(logic [9:0] v);
        if (v == V_OVF) return 8'h01 << TOV0;
        if (v == V_CA)  return 8'h01 << OCF0A;
        if (v == V_CB)  return 8'h01 << OCF0B;
        return 8'h00;
    endfunction

    task automatic model_clear();
        m_busy = 0; m_jump = 0; m_guard = 0;
        q_addr.delete(); q_data.delete();
    endtask

    task automatic model_check();
        logic       e_we, e_sreg, e_spwe, e_pcl;
        logic [7:0] e_addr, e_data, e_spwd, e_tifr;
        logic [9:0] e_pcn;
        e_we = 0; e_sreg = 0; e_spwe = 0; e_pcl = 0;
        e_addr = 0; e_data = 0; e_spwd = 0; e_tifr = 0; e_pcn = 0;
        if (q_addr.size() > 0) begin
            e_we   = 1;
            e_addr = q_addr[0];
            e_data = q_data[0];
            e_sreg = mem_ready && q_addr.size() == 2;
            e_spwe = mem_ready && q_addr.size() == 1;
            e_spwd = e_spwe ? m_final : 8'h00;
        end else if (m_jump) begin
            e_pcl  = 1;
            e_pcn  = m_vec;
            e_tifr = ref_mask(m_vec);
        end
        chk("stall", 32'(stall), 32'(m_busy));
        chk("mem_wr_en", 32'(mem_wr_en), 32'(e_we));
        chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        chk("mem_wr_data", 32'(mem_wr_data), 32'(e_data));
        chk("sreg_i_clr", 32'(sreg_i_clr), 32'(e_sreg));
        chk("sp_wr_en", 32'(sp_wr_en), 32'(e_spwe));
        chk("sp_wr_data", 32'(sp_wr_data), 32'(e_spwd));
        chk("pc_load", 32'(pc_load), 32'(e_pcl));
        chk("pc_next", 32'(pc_next), 32'(e_pcn));
        chk("tifr_clr", 32'(tifr_clr), 32'(e_tifr));
    endtask

    task automatic model_adv();
        if (!m_busy) begin
            if (irq && instr_boundary) begin
                m_busy = 1;
                q_addr.push_back(sp);
                q_data.push_back(pc[7:0]);
                q_addr.push_back(sp - 8'd1);
                q_data.push_back(8'(pc >> 8));
                m_final = sp - 8'd2;
                m_vec   = vector;
                acc_cyc = cyc;
            end
        end else if (q_addr.size() > 0) begin
            if (mem_ready) begin
                void'(q_addr.pop_front());
                void'(q_data.pop_front());
                if (q_addr.size() == 0) m_jump = 1;
            end
        end else if (m_jump) begin
            m_jump = 0; m_guard = 1;
        end else begin
            m_guard = 0; m_busy = 0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        model_check();
        if (pc_load) pcl_cyc = cyc;
        n_sreg += int'(sreg_i_clr);
        n_spwe += int'(sp_wr_en);
        n_pcl  += int'(pc_load);
        @(posedge clk);
        model_adv();
        cyc++;
        #1;
    endtask

    task automatic run_out(string name);
        int n;
        n = 0;
        while (m_busy && n < 20) begin
            cycle();
            n++;
        end
        if (m_busy) chk({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic chk_zero(string name);
        chk({name, "_stall"}, 32'(stall), 0);
        chk({name, "_outs"},
            32'({mem_wr_en, sp_wr_en, sreg_i_clr, pc_load}), 0);
        chk({name, "_buses"},
            32'(mem_addr | mem_wr_data | sp_wr_data | tifr_clr), 0);
        chk({name, "_pcn"}, 32'(pc_next), 0);
    endtask

    task automatic do_reset();
        reset = 1;
        #2;
        chk_zero("reset");
        @(posedge clk);
        #1;
        reset = 0;
        model_clear();
    endtask

    task automatic clr_counts();
        n_sreg = 0; n_spwe = 0; n_pcl = 0;
        acc_cyc = -100; pcl_cyc = -200;
    endtask

    typedef struct {
        logic       irq;
        logic [9:0] vec;
        logic       ib;
        logic [9:0] pc;
        logic [7:0] sp;
        logic       mr;
        logic       stall, we;
        logic [7:0] addr, data;
        logic       sreg, spwe;
        logic [7:0] spwd;
        logic       pcl;
        logic [9:0] pcn;
        logic [7:0] tifr;
    } row_t;

    row_t tbl[$];

    initial begin
        reset = 1; irq = 0; vector = 0; instr_boundary = 0;
        pc = 0; sp = 0; mem_ready = 1;
        cyc = 0;
        model_clear();
        clr_counts();

        // OVF entry, sp=0x5F pc=0x123
        tbl.push_back('{1, V_OVF, 1, 10'h123, 8'h5F, 1,
                        0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 1,
                        1, 1, 8'h5F, 8'h23, 1, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 1,
                        1, 1, 8'h5E, 8'h01, 0, 1, 8'h5D, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 1,
                        1, 0, 0, 0, 0, 0, 0, 1, V_OVF, 8'h01});
        tbl.push_back('{1, V_OVF, 1, 0, 0, 1,
                        1, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 1,
                        0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        // COMPA entry with sp wrapping through zero
        tbl.push_back('{1, V_CA, 1, 10'h2A5, 8'h00, 1,
                        0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 1,
                        1, 1, 8'h00, 8'hA5, 1, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 1,
                        1, 1, 8'hFF, 8'h02, 0, 1, 8'hFE, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 1,
                        1, 0, 0, 0, 0, 0, 0, 1, V_CA, 8'h02});
        tbl.push_back('{0, 0, 0, 0, 0, 1,
                        1, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 1,
                        0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        // unmapped vector, irq held high through guard
        tbl.push_back('{1, 10'h3FF, 1, 10'h3FF, 8'h80, 1,
                        0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 10'h3FF, 1, 0, 0, 1,
                        1, 1, 8'h80, 8'hFF, 1, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 10'h3FF, 1, 0, 0, 1,
                        1, 1, 8'h7F, 8'h03, 0, 1, 8'h7E, 0, 0, 0});
        tbl.push_back('{1, 10'h3FF, 1, 0, 0, 1,
                        1, 0, 0, 0, 0, 0, 0, 1, 10'h3FF, 8'h00});
        tbl.push_back('{1, 10'h3FF, 1, 0, 0, 1,
                        1, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 10'h3FF, 0, 0, 0, 1,
                        0, 0, 0, 0, 0, 0, 0, 0, 0, 0});

        #1;
        do_reset();

        for (int i = 0; i < tbl.size(); i++) begin
            irq = tbl[i].irq; vector = tbl[i].vec;
            instr_boundary = tbl[i].ib; pc = tbl[i].pc;
            sp = tbl[i].sp; mem_ready = tbl[i].mr;
            @(negedge clk);
            chk($sformatf("t%0d_stall", i), 32'(stall), 32'(tbl[i].stall));
            chk($sformatf("t%0d_we", i), 32'(mem_wr_en), 32'(tbl[i].we));
            chk($sformatf("t%0d_addr", i), 32'(mem_addr), 32'(tbl[i].addr));
            chk($sformatf("t%0d_data", i), 32'(mem_wr_data), 32'(tbl[i].data));
            chk($sformatf("t%0d_sreg", i), 32'(sreg_i_clr), 32'(tbl[i].sreg));
            chk($sformatf("t%0d_spwe", i), 32'(sp_wr_en), 32'(tbl[i].spwe));
            chk($sformatf("t%0d_spwd", i), 32'(sp_wr_data), 32'(tbl[i].spwd));
            chk($sformatf("t%0d_pcl", i), 32'(pc_load), 32'(tbl[i].pcl));
            chk($sformatf("t%0d_pcn", i), 32'(pc_next), 32'(tbl[i].pcn));
            chk($sformatf("t%0d_tifr", i), 32'(tifr_clr), 32'(tbl[i].tifr));
            @(posedge clk);
            #1;
        end
        irq = 0;

        // irq waits for an instruction boundary
        do_reset();
        clr_counts();
        irq = 1; vector = V_OVF; pc = 10'h155; sp = 8'h40;
        instr_boundary = 0; mem_ready = 1;
        repeat (4) cycle();
        chk("wait_no_accept", 32'(acc_cyc), 32'(-100));
        instr_boundary = 1;
        cycle();
        instr_boundary = 0; irq = 0;
        run_out("wait");
        chk("wait_latency", 32'(pcl_cyc - acc_cyc), 32'd3);
        chk("wait_pulses", 32'({n_sreg[3:0], n_spwe[3:0], n_pcl[3:0]}),
            32'h111);

        // memory back-pressure in PUSH_LO
        clr_counts();
        irq = 1; vector = V_CB; pc = 10'h2C7; sp = 8'h10;
        instr_boundary = 1; mem_ready = 1;
        cycle();
        irq = 0; instr_boundary = 0; mem_ready = 0;
        repeat (2) cycle();
        chk("bp_no_sreg", 32'(n_sreg), 32'd0);
        mem_ready = 1;
        run_out("bp");
        chk("bp_latency", 32'(pcl_cyc - acc_cyc), 32'd5);
        chk("bp_pulses", 32'({n_sreg[3:0], n_spwe[3:0], n_pcl[3:0]}),
            32'h111);

        // asynchronous reset while pushing the high byte
        clr_counts();
        irq = 1; vector = V_CA; pc = 10'h0AB; sp = 8'h33;
        instr_boundary = 1; mem_ready = 1;
        cycle();
        irq = 0; instr_boundary = 0;
        cycle();
        chk("pre_reset_stall", 32'(stall), 32'd1);
        #2;
        reset = 1;
        #1;
        chk_zero("async_reset");
        model_clear();
        @(posedge clk);
        #1;
        reset = 0;
        clr_counts();
        irq = 1; vector = V_OVF; pc = 10'h301; sp = 8'h22;
        instr_boundary = 1;
        cycle();
        irq = 0; instr_boundary = 0;
        run_out("post_reset");
        chk("post_reset_latency", 32'(pcl_cyc - acc_cyc), 32'd3);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [9:0] vs[4];
            vs[0] = V_OVF; vs[1] = V_CA; vs[2] = V_CB;
            vs[3] = 10'($urandom);
            irq = ($urandom % 3) != 0;
            instr_boundary = $urandom % 2;
            vector = vs[$urandom % 4];
            pc = 10'($urandom);
            sp = 8'($urandom);
            mem_ready = ($urandom % 4) != 0;
            cycle();
        end
        irq = 0; mem_ready = 1;
        run_out("rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
